// File: rtl/mips_pkg.sv
// mips_pkg: shared multiply/divide types, constants and sign helpers.
// Rev 1.0
`default_nettype none
package mips_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_t;

  // Magnitude of a two's-complement value; the most negative value maps to itself.
  function automatic logic [MD_WIDTH-1:0] md_abs(input logic [MD_WIDTH-1:0] x);
    return x[MD_WIDTH-1] ? (~x + MD_WIDTH'(1)) : x;
  endfunction

  function automatic logic [MD_WIDTH-1:0] md_neg_if(input logic [MD_WIDTH-1:0] x,
                                                   input logic en);
    return en ? (~x + MD_WIDTH'(1)) : x;
  endfunction

  function automatic logic [2*MD_WIDTH-1:0] md_neg2_if(input logic [2*MD_WIDTH-1:0] x,
                                                      input logic en);
    return en ? (~x + (2*MD_WIDTH)'(1)) : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_regs.sv
// hilo_regs: architectural HI/LO pair; operation results beat moves, moves only when idle.
// Rev 1.0
`default_nettype none
module hilo_regs #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             idle_i,
  input  logic             start_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             res_we_i,
  input  logic [WIDTH-1:0] res_hi_i,
  input  logic [WIDTH-1:0] res_lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             w_move_ok;

  // A start in the same idle cycle swallows any pending move.
  assign w_move_ok = idle_i && !start_i;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (res_we_i) begin
      hi_d = res_hi_i;
      lo_d = res_lo_i;
    end else if (w_move_ok) begin
      if (mthi_i) hi_d = wdata_i;
      if (mtlo_i) lo_d = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
// mult_div_unit: fixed-latency shift-add multiply / restoring divide owning HI/LO.
// Rev 1.0
`default_nettype none
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t       state_q, state_d;
  muldiv_op_t          op_q, op_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0]    opb_q, opb_d;
  logic                negq_q, negq_d;
  logic                negr_q, negr_d;
  logic                divz_q, divz_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                w_signed, w_is_div, w_ge, w_res_we;
  logic [WIDTH-1:0]    w_a_mag, w_b_mag, w_diff, w_quo, w_rem, w_res_hi, w_res_lo;
  logic [WIDTH:0]      w_sum, w_shifted;
  logic [2*WIDTH-1:0]  w_prod;

  assign w_signed = !op[0];
  assign w_a_mag  = w_signed ? md_abs(a) : a;
  assign w_b_mag  = w_signed ? md_abs(b) : b;
  assign w_is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign w_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};

  // Divide: acc low half shifts dividend bits out and quotient bits in.
  assign w_shifted = {rem_q, acc_q[WIDTH-1]};
  assign w_ge      = (w_shifted >= {1'b0, opb_q});
  assign w_diff    = w_shifted[WIDTH-1:0] - opb_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    opb_d   = opb_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    divz_d  = divz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    w_res_we = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = muldiv_op_t'(op);
          cnt_d   = '0;
          rem_d   = '0;
          acc_d   = {{WIDTH{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
          opb_d   = op[1] ? w_b_mag : w_a_mag;
          negq_d  = w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          negr_d  = w_signed && a[WIDTH-1];
          divz_d  = op[1] && (b == '0);
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_is_div) begin
          rem_d              = w_ge ? w_diff : w_shifted[WIDTH-1:0];
          acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], w_ge};
        end else begin
          acc_d = {w_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + MD_CNT_W'(1);
        if (cnt_q == MD_CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        w_res_we = 1'b1;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A zero divisor leaves |a| in the remainder, so HI recovers the original a.
  assign w_prod   = md_neg2_if(acc_q, negq_q);
  assign w_quo    = divz_q ? '1 : md_neg_if(acc_q[WIDTH-1:0], negq_q);
  assign w_rem    = md_neg_if(rem_q, negr_q);
  assign w_res_hi = w_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
  assign w_res_lo = w_is_div ? w_quo : w_prod[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MULT;
      cnt_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      opb_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      divz_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      opb_q   <= opb_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      divz_q  <= divz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  hilo_regs #(.WIDTH(WIDTH)) u_hilo (
    .clk      (clk),
    .rst_n    (rst_n),
    .idle_i   (state_q == ST_IDLE),
    .start_i  (start),
    .mthi_i   (mthi),
    .mtlo_i   (mtlo),
    .wdata_i  (wdata),
    .res_we_i (w_res_we),
    .res_hi_i (w_res_hi),
    .res_lo_i (w_res_lo),
    .hi_o     (hi),
    .lo_o     (lo)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit that issues MULT, MULTU, DIV and DIVU and owns the architectural HI/LO registers of the MIPS-compatible core. It sits in the execute stage beside the combinational ALU:
- the ALU returns its result in the same cycle;
- this block accepts one operation per start pulse, runs it over a fixed number of cycles, and signals completion.

The decode/stall logic uses `busy` to hold MFHI/MFLO and any new multiply/divide until the result is written.

## Interface
Parameters:
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset, synchronous and active-low; one clock domain only.
- `start` input 1: issue request, sampled only in IDLE.
- `op` input 2: operation, sampled with `start`. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a` input WIDTH: rs operand (multiplicand / dividend).
- `b` input WIDTH: rt operand (multiplier / divisor).
- `mthi` input 1: write `wdata` to HI, honoured only in IDLE.
- `mtlo` input 1: write `wdata` to LO, honoured only in IDLE.
- `wdata` input WIDTH: MTHI/MTLO data.
- `busy` output 1: operation in flight.
- `done` output 1: one-cycle pulse, HI/LO just updated by an operation.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
States:
- IDLE → RUN on `start`.
- RUN → FIX when the iteration counter reaches WIDTH−1.
- FIX → IDLE unconditionally.

Reset:
- `rst_n`=0 at any edge, including mid-operation, forces IDLE.
- Reset clears `hi`, `lo`, counter and working registers to 0, and drives `busy`=0, `done`=0.
- An aborted operation leaves no trace.

On `start` in IDLE:
- Latch `op`.
- For signed ops (MULT, DIV), latch magnitudes |a| and |b| in WIDTH bits (0x80000000 → 0x80000000 unsigned). Latch the negate flags: product/quotient = sign(a)^sign(b), remainder = sign(a).
- For unsigned ops, latch the operands as-is with flags = 0.

RUN performs WIDTH iterations:
- Multiply: shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- Divide: restoring division, one quotient bit per cycle; remainder WIDTH+1 bits internally.

FIX:
- Apply two's-complement negation per the flags.
- Write the result: multiply gives HI = product[63:32], LO = product[31:0]; divide gives HI = remainder, LO = quotient.

Divide by zero (b = 0), all divide ops:
- Result is fixed: HI = a (original, unconditioned), LO = 0xFFFFFFFF.
- Same latency; no exception.

Signed overflow, DIV 0x80000000 / 0xFFFFFFFF:
- HI = 0, LO = 0x80000000, which falls out of magnitude/negate naturally.

Ignored requests:
- `start` while `busy` is ignored; no queueing.
- `mthi`/`mtlo` while `busy` are ignored.

Same-cycle priority in IDLE:
- `start` beats `mthi`/`mtlo`; the moves are dropped.
- `mthi` and `mtlo` together write `wdata` to both.

`hi`/`lo` change only on reset, honoured MTHI/MTLO, or FIX.

## Timing
- `start` sampled at edge E0. `busy`=1 in the cycle after E0 through the FIX cycle.
- RUN occupies edges E1..E32. FIX writes HI/LO at edge E33.
- After E33: `busy`=0 and `done`=1 for exactly one cycle. A new `start` is accepted in that same cycle.
- Total issue-to-result latency is WIDTH+1 edges (33). Latency is identical for all ops and all operand values; no early termination.
- MTHI/MTLO take effect at the sampling edge; visible on `hi`/`lo` the next cycle.
- All outputs are registered.

## Structure
- Shared package `mips_pkg` holds:
  - the `muldiv_op_t` enum (MULT, MULTU, DIV, DIVU with the encodings above);
  - the `muldiv_state_t` enum (IDLE, RUN, FIX);
  - the iteration-count width constant.
- Magnitude/negate helpers are package functions, not modules.
- One sub-module is natural: `hilo_regs`. It holds the HI/LO register pair with reset, move-port write, and result write, enforcing the priority rules.
- Everything else (FSM, counter, shift-add / restoring datapath) is in `mult_div_unit`.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → `done` 33 edges after start; HI=0xFFFFFFFE, LO=0x00000001; `busy` high exactly 33 cycles.
- MULT a=−3 (0xFFFFFFFD), b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIV a=−7, b=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIVU 100/7 → LO=14, HI=2. DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- DIVU a=0x1234, b=0 → HI=0x1234, LO=0xFFFFFFFF, same latency.
- Idle MTHI 0xAAAA5555 then MTLO 0x5555AAAA → hi/lo read back. During busy: MTHI and a second `start` are ignored and the first result is unaffected. `start` and `mthi` in the same idle cycle → only the op result lands.
- Assert `rst_n`=0 at RUN cycle 10 → next cycle `busy`=0, `hi`=`lo`=0, no `done`. A fresh MULTU 6×7 then gives LO=42, HI=0.
